// File: rtl/reg_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_arb_pkg
// Purpose  : Shared types, constants and helpers for the register write arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package reg_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    localparam int MAX_HOLD   = 15;
    localparam int HOLD_CNT_W = $clog2(MAX_HOLD + 1);

    // A single requester still needs a 1-bit index so ports never collapse to zero width.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/reg_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : rr_pick
// Purpose  : Combinational round-robin picker; first set request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module rr_pick import reg_arb_pkg::*; #(
    parameter  int NREQ = 4,
    localparam int IDXW = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDXW-1:0] ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDXW-1:0] grant_idx,
    output logic            any_grant
);

    localparam int SUMW = IDXW + 1;

    logic [SUMW-1:0] w_sum;
    logic [IDXW-1:0] w_pos;

    // Wrap with a single subtraction so non-power-of-2 NREQ never yields an invalid index.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = 1'b0;
        w_sum     = '0;
        w_pos     = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = {1'b0, ptr} + SUMW'(k);
            if (w_sum >= SUMW'(NREQ)) begin
                w_sum = w_sum - SUMW'(NREQ);
            end
            w_pos = w_sum[IDXW-1:0];
            if (!any_grant && req[w_pos]) begin
                any_grant    = 1'b1;
                grant[w_pos] = 1'b1;
                grant_idx    = w_pos;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : reg_write_arbiter
// Purpose  : Round-robin arbiter writing one shared register, with a hold window.
// Revision : 1.0 - initial release
// ============================================================================
module reg_write_arbiter import reg_arb_pkg::*; #(
    parameter  int             WDT      = 1,
    parameter  logic [WDT-1:0] RST_VAL  = '0,
    parameter  int             NREQ     = 4,
    parameter  int             HOLD_CYC = 2,
    localparam int             IDXW     = idx_width(NREQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [NREQ*WDT-1:0] req_data,
    output logic [NREQ-1:0]     req_ready,
    output logic [WDT-1:0]      d_out,
    output logic                upd_pulse,
    output logic [IDXW-1:0]     upd_src,
    output logic                busy
);

    localparam arb_state_t            c_ST_IDLE   = IDLE;
    localparam arb_state_t            c_ST_HOLD   = HOLD;
    localparam logic [HOLD_CNT_W-1:0] c_HOLD_INIT = (HOLD_CYC > 0) ? HOLD_CNT_W'(HOLD_CYC - 1) : '0;
    localparam logic [IDXW-1:0]       c_LAST_IDX  = IDXW'(NREQ - 1);

    arb_state_t            r_state;
    logic [HOLD_CNT_W-1:0] r_cnt;
    logic [IDXW-1:0]       r_ptr;
    logic [WDT-1:0]        r_data;
    logic                  r_upd_pulse;
    logic [IDXW-1:0]       r_upd_src;

    logic [WDT-1:0]        w_req_data [NREQ];
    logic [NREQ-1:0]       w_pick_grant;
    logic [IDXW-1:0]       w_pick_idx;
    logic                  w_pick_any;
    logic                  w_accepting;
    logic                  w_write;
    logic [IDXW-1:0]       w_ptr_next;

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign w_req_data[gi] = req_data[gi*WDT +: WDT];
        end
    endgenerate

    rr_pick #(
        .NREQ (NREQ)
    ) u_pick (
        .req       (req_valid),
        .ptr       (r_ptr),
        .grant     (w_pick_grant),
        .grant_idx (w_pick_idx),
        .any_grant (w_pick_any)
    );

    // Gating on rst keeps every ready low for the whole reset interval, not just after the edge.
    assign w_accepting = (r_state == c_ST_IDLE) && !rst;
    assign req_ready   = w_accepting ? w_pick_grant : '0;
    assign w_write     = w_accepting && w_pick_any;
    assign w_ptr_next  = (w_pick_idx == c_LAST_IDX) ? '0 : w_pick_idx + IDXW'(1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_cnt       <= '0;
            r_ptr       <= '0;
            r_data      <= RST_VAL;
            r_upd_pulse <= 1'b0;
            r_upd_src   <= '0;
        end else begin
            r_upd_pulse <= w_write;
            if (w_write) begin
                r_data    <= w_req_data[w_pick_idx];
                r_upd_src <= w_pick_idx;
                r_ptr     <= w_ptr_next;
                // With no hold window the arbiter stays open for back-to-back writes.
                if (HOLD_CYC > 0) begin
                    r_state <= c_ST_HOLD;
                    r_cnt   <= c_HOLD_INIT;
                end
            end else if (r_state == c_ST_HOLD) begin
                if (r_cnt == '0) begin
                    r_state <= c_ST_IDLE;
                end else begin
                    r_cnt <= r_cnt - HOLD_CNT_W'(1);
                end
            end
        end
    end

    assign d_out     = r_data;
    assign upd_pulse = r_upd_pulse;
    assign upd_src   = r_upd_src;
    assign busy      = (r_state == c_ST_HOLD);

    // Requesters must keep valid and data steady until their grant.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_contract
            a_valid_held : assert property (@(posedge clk) disable iff (rst)
                (req_valid[gi] && !req_ready[gi]) |=> req_valid[gi]);
            a_data_stable : assert property (@(posedge clk) disable iff (rst)
                (req_valid[gi] && !req_ready[gi]) |=> $stable(req_data[gi*WDT +: WDT]));
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_reg_write_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_write_arbiter
// Purpose  : Scoreboard bench for reg_write_arbiter (HOLD_CYC=2 and HOLD_CYC=0 builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_write_arbiter;

    localparam int           NREQ     = 4;
    localparam int           WDT      = 8;
    localparam int           HOLD_CYC = 2;
    localparam int           IDXW     = 2;
    localparam logic [7:0]   RST_VAL  = 8'h00;

    typedef struct packed {
        logic [IDXW-1:0] src;
        logic [WDT-1:0]  data;
    } wr_t;

    logic                clk = 1'b0;
    logic                rst;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ*WDT-1:0] req_data;
    logic [NREQ-1:0]     req_ready;
    logic [WDT-1:0]      d_out;
    logic                upd_pulse;
    logic [IDXW-1:0]     upd_src;
    logic                busy;

    logic                rst0;
    logic [NREQ-1:0]     req_valid0;
    logic [NREQ*WDT-1:0] req_data0;
    logic [NREQ-1:0]     req_ready0;
    logic [WDT-1:0]      d_out0;
    logic                upd_pulse0;
    logic [IDXW-1:0]     upd_src0;
    logic                busy0;

    int              n_checks = 0;
    int              n_fail   = 0;
    int              m_ptr    = 0;
    int              m_hold   = 0;
    logic [WDT-1:0]  m_dout   = RST_VAL;
    logic [NREQ-1:0] granted_mask = '0;
    wr_t             exp_q[$];
    bit              model_en = 1'b0;
    bit              h0_done  = 1'b0;

    always #5 clk = ~clk;

    reg_write_arbiter #(
        .WDT(WDT), .RST_VAL(RST_VAL), .NREQ(NREQ), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
        .req_ready(req_ready), .d_out(d_out), .upd_pulse(upd_pulse),
        .upd_src(upd_src), .busy(busy)
    );

    reg_write_arbiter #(
        .WDT(WDT), .RST_VAL(RST_VAL), .NREQ(NREQ), .HOLD_CYC(0)
    ) dut_h0 (
        .clk(clk), .rst(rst0), .req_valid(req_valid0), .req_data(req_data0),
        .req_ready(req_ready0), .d_out(d_out0), .upd_pulse(upd_pulse0),
        .upd_src(upd_src0), .busy(busy0)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Drop each request as it is granted, bounded so a stuck DUT cannot hang the run.
    task automatic drain(input int max_cyc);
        int c = 0;
        while (req_valid != '0 && c < max_cyc) begin
            step();
            req_valid = req_valid & ~granted_mask;
            c++;
        end
        if (req_valid != '0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: pending 0x%0h after %0d cycles", req_valid, max_cyc);
            req_valid = '0;
        end
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_hold = 0;
        m_dout = RST_VAL;
        exp_q.delete();
    endtask

    // Reference model: decides each upcoming edge's winner from the arbitration rules.
    initial begin : p_model
        int              win;
        logic [NREQ-1:0] exp_ready;
        forever begin
            @(negedge clk);
            win          = -1;
            exp_ready    = '0;
            granted_mask = '0;
            if (model_en && !rst) begin
                if (m_hold == 0) begin
                    for (int k = 0; k < NREQ; k++) begin
                        if (win < 0 && req_valid[(m_ptr + k) % NREQ]) begin
                            win = (m_ptr + k) % NREQ;
                        end
                    end
                end
                if (win >= 0) exp_ready[win] = 1'b1;
                check("req_ready", req_ready, exp_ready);
                check("busy", busy, m_hold > 0);
                if (win >= 0) begin
                    exp_q.push_back({IDXW'(win), req_data[win*WDT +: WDT]});
                    m_ptr            = (win + 1) % NREQ;
                    m_hold           = HOLD_CYC;
                    granted_mask[win] = 1'b1;
                end else if (m_hold > 0) begin
                    m_hold--;
                end
            end
        end
    end

    // Monitor: every update pulse must match the oldest expected write.
    initial begin : p_monitor
        wr_t e;
        forever begin
            @(posedge clk);
            #1;
            if (model_en && !rst) begin
                if (upd_pulse) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_write: upd_src=%0d d_out=0x%0h, no write expected", upd_src, d_out);
                    end else begin
                        e = exp_q.pop_front();
                        check("upd_src", upd_src, e.src);
                        m_dout = e.data;
                    end
                end else begin
                    check("missing_write", exp_q.size(), 0);
                end
                check("d_out", d_out, m_dout);
            end
        end
    end

    initial begin : p_hold0
        rst0       = 1'b1;
        req_valid0 = '0;
        req_data0  = '0;
        repeat (2) @(posedge clk);
        #2;
        req_valid0 = 4'b0011;
        req_data0  = 32'h0000_2120;
        #1 rst0 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            check("h0_upd_pulse", upd_pulse0, 1);
            check("h0_upd_src", upd_src0, k % 2);
            check("h0_d_out", d_out0, (k % 2) ? 8'h21 : 8'h20);
            check("h0_busy", busy0, 0);
            if (k < 6) check("h0_req_ready", req_ready0, (k % 2) ? 4'b0001 : 4'b0010);
            #1;
            if (k == 6) req_valid0 = 4'b0010;
            if (k == 7) req_valid0 = '0;
        end
        @(posedge clk);
        #1;
        check("h0_idle_pulse", upd_pulse0, 0);
        h0_done = 1'b1;
    end

    initial begin : p_main
        int grants;
        int c;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("rst_d_out", d_out, RST_VAL);
        check("rst_upd_pulse", upd_pulse, 0);
        check("rst_upd_src", upd_src, 0);
        check("rst_busy", busy, 0);

        // Rotation: all valid while reset is released in the same cycle.
        #1;
        req_valid = 4'b1111;
        req_data  = 32'h1312_1110;
        #0.5;
        check("rst_req_ready", req_ready, 0);
        #0.5;
        rst      = 1'b0;
        model_en = 1'b1;
        grants   = 0;
        c        = 0;
        while (grants < 4 && c < 30) begin
            step();
            grants += $countones(granted_mask);
            c++;
        end
        drain(30);
        repeat (HOLD_CYC + 1) step();

        // Single write from requester 2.
        req_valid             = 4'b0100;
        req_data[23:16]       = 8'h3C;
        drain(10);
        repeat (HOLD_CYC + 1) step();

        // Requester 3 alone, then 0 and 3 together: pointer has wrapped to 0.
        req_valid       = 4'b1000;
        req_data[31:24] = 8'h5A;
        drain(10);
        repeat (HOLD_CYC + 1) step();
        req_valid       = 4'b1001;
        req_data[7:0]   = 8'hE1;
        req_data[31:24] = 8'hE3;
        drain(20);
        repeat (HOLD_CYC + 1) step();

        // Write A5 then reset during the first busy cycle.
        req_valid       = 4'b0100;
        req_data[23:16] = 8'hA5;
        step();
        req_valid = '0;
        #1;
        rst = 1'b1;
        model_reset();
        #1;
        check("midhold_d_out", d_out, RST_VAL);
        check("midhold_busy", busy, 0);
        check("midhold_upd_pulse", upd_pulse, 0);
        check("midhold_req_ready", req_ready, 0);
        step();
        req_valid      = 4'b0010;
        req_data[15:8] = 8'hC3;
        #1 rst = 1'b0;
        drain(5);
        repeat (HOLD_CYC + 1) step();

        // Randomised traffic obeying the requester contract.
        for (int cyc = 0; cyc < 600; cyc++) begin
            step();
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || granted_mask[i]) begin
                    if ($urandom_range(99) < 35) begin
                        req_valid[i]             = 1'b1;
                        req_data[i*WDT +: WDT]   = 8'($urandom);
                    end else begin
                        req_valid[i] = 1'b0;
                    end
                end
            end
        end
        drain(60);
        repeat (HOLD_CYC + 2) step();
        check("queue_empty", exp_q.size(), 0);

        c = 0;
        while (!h0_done && c < 50) begin
            step();
            c++;
        end
        check("h0_finished", h0_done, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin : p_watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
